// File: rtl/divider_seq_16x8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : divider_seq_16x8                                           |
// | Description : Sequential 16-bit / 8-bit unsigned restoring divider with  |
// |               a valid/ready handshake on both sides. It performs one     |
// |               quotient bit per clock, MSB first.                         |
// | Config      : define DIV_ZERO_CHECK_EN to short-cut a zero divisor and   |
// |               report it on div_by_zero. Otherwise the full 16 steps run  |
// |               and div_by_zero is tied to 0.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module divider_seq_16x8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The finishing edge comes after the 16th step. It is the 17th edge after acceptance.
  localparam logic [4:0] c_last_step = 5'd16;

  state_t      r_state;
  state_t      w_state_nxt;

  // The dividend shifts out of the top of r_dvd_q while quotient bits shift in
  // at the bottom. After 16 steps the register holds the quotient.
  logic [15:0] r_dvd_q;
  logic [7:0]  r_divisor;
  logic [7:0]  r_rem;
  logic [4:0]  r_count;
  logic [15:0] r_quotient;
  logic [7:0]  r_remainder;

  logic [8:0]  w_rem9;
  logic        w_ge;
  logic [7:0]  w_diff;
  logic [7:0]  w_rem_nxt;
  logic        w_zero_skip;
  logic        w_finish;

  // One restoring step: bring in the next dividend bit, then subtract if the divisor fits.
  always_comb begin
    w_rem9    = {r_rem, r_dvd_q[15]};
    w_ge      = (w_rem9 >= {1'b0, r_divisor});
    // Once w_ge holds, the true difference is below the divisor. The low
    // byte of the 9-bit subtraction is therefore exact.
    w_diff    = w_rem9[7:0] - r_divisor;
    w_rem_nxt = w_ge ? w_diff : w_rem9[7:0];
  end

`ifdef DIV_ZERO_CHECK_EN
  // A zero divisor spends a single cycle in BUSY without stepping.
  assign w_zero_skip = (r_divisor == 8'd0);
`else
  assign w_zero_skip = 1'b0;
`endif

  assign w_finish = (r_count == c_last_step) || w_zero_skip;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_finish) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on acceptance, iterate in BUSY, publish the result on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd_q     <= 16'd0;
      r_divisor   <= 8'd0;
      r_rem       <= 8'd0;
      r_count     <= 5'd0;
      r_quotient  <= 16'd0;
      r_remainder <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd_q   <= dividend;
            r_divisor <= divisor;
            r_rem     <= 8'd0;
            r_count   <= 5'd0;
          end
        end
        BUSY: begin
          if (w_zero_skip) begin
            r_quotient  <= 16'hFFFF;
            r_remainder <= r_dvd_q[7:0];
          end else if (w_finish) begin
            r_quotient  <= r_dvd_q;
            r_remainder <= r_rem;
          end else begin
            r_rem   <= w_rem_nxt;
            r_dvd_q <= {r_dvd_q[14:0], w_ge};
            r_count <= r_count + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  logic r_div_by_zero;

  // The zero flag is updated together with the result and held like it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_by_zero <= 1'b0;
    end else if (r_state == BUSY && w_finish) begin
      r_div_by_zero <= w_zero_skip;
    end
  end

  assign div_by_zero = r_div_by_zero;
`else
  assign div_by_zero = 1'b0;
`endif

  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_divider_seq_16x8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_divider_seq_16x8                                        |
// | Description : Self-checking bench for divider_seq_16x8. It uses a        |
// |               transaction-level reference model with plain / and %,      |
// |               directed literal cases and randomized traffic.             |
// | Config      : honours DIV_ZERO_CHECK_EN the same way as the design.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_divider_seq_16x8;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif
  localparam int ZLAT = ZCHK ? 1 : 17;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dividend  = 16'd0;
  logic [7:0]  divisor   = 8'd0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  divider_seq_16x8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model at the transaction level. The result is computed with / and %.
  // Latency is modelled as a plain countdown.
  int          m_state;   // 0 idle, 1 busy, 2 done
  int          m_cnt;
  int          m_acc;
  int          m_del;
  int          d_del;
  logic [15:0] m_q, p_q;
  logic [7:0]  m_r, p_r;
  logic        m_z, p_z;

  // Advance the model on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_cnt <= 0; m_acc <= 0; m_del <= 0;
      m_q <= 16'd0; m_r <= 8'd0; m_z <= 1'b0;
      p_q <= 16'd0; p_r <= 8'd0; p_z <= 1'b0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          m_state <= 1;
          m_acc   <= m_acc + 1;
          if (divisor == 8'd0) begin
            p_q <= 16'hFFFF; p_r <= dividend[7:0]; p_z <= ZCHK; m_cnt <= ZLAT;
          end else begin
            p_q <= dividend / {8'd0, divisor};
            p_r <= 8'(dividend % {8'd0, divisor});
            p_z <= 1'b0;
            m_cnt <= 17;
          end
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_state <= 2; m_q <= p_q; m_r <= p_r; m_z <= p_z;
          end
        end
        default: if (out_ready) begin
          m_state <= 0;
          m_del   <= m_del + 1;
        end
      endcase
    end
  end

  // Count the results the DUT actually hands over.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_del <= 0;
    else if (out_valid && out_ready) d_del <= d_del + 1;
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("in_ready",    32'(in_ready),    32'(m_state == 0));
    chk("out_valid",   32'(out_valid),   32'(m_state == 2));
    chk("quotient",    32'(quotient),    32'(m_q));
    chk("remainder",   32'(remainder),   32'(m_r));
    chk("div_by_zero", 32'(div_by_zero), 32'(m_z));
  end

  // Directed operation with literal expectations. It starts just after a rising edge while the DUT is in IDLE.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [7:0] b,
                        input int hold, input logic [15:0] eq, input logic [7:0] er,
                        input int elat, input logic ez);
    int n;
    chk({nm, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(elat));
    chk({nm, "_q"},   32'(quotient),    32'(eq));
    chk({nm, "_r"},   32'(remainder),   32'(er));
    chk({nm, "_dbz"}, 32'(div_by_zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_q"},     32'(quotient),  32'(eq));
      chk({nm, "_hold_r"},     32'(remainder), 32'(er));
      chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_ready"}, 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_idle_ready"}, 32'(in_ready),  32'd1);
    chk({nm, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_idle_q"},     32'(quotient),  32'(eq));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q",     32'(quotient),  32'd0);
    chk("reset_r",     32'(remainder), 32'd0);
    chk("reset_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("d1000_7",   16'd1000,  8'd7,   0, 16'd142,   8'd6,  17, 1'b0);
    run_op("dffff_255", 16'hFFFF,  8'd255, 0, 16'd257,   8'd0,  17, 1'b0);
    run_op("dffff_1",   16'hFFFF,  8'd1,   0, 16'hFFFF,  8'd0,  17, 1'b0);
    run_op("d100_0",    16'd100,   8'd0,   0, 16'hFFFF,  8'h64, ZLAT, ZCHK);
    run_op("d12345_10", 16'd12345, 8'd10,  5, 16'd1234,  8'd5,  17, 1'b0);

    // Abort a division part-way through with an asynchronous reset.
    in_valid = 1'b1; dividend = 16'd5000; divisor = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_q",     32'(quotient),    32'd0);
    chk("abort_r",     32'(remainder),   32'd0);
    chk("abort_dbz",   32'(div_by_zero), 32'd0);
    chk("abort_valid", 32'(out_valid),   32'd0);
    chk("abort_ready", 32'(in_ready),    32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("d200_9", 16'd200, 8'd9, 0, 16'd22, 8'd2, 17, 1'b0);

    // Random traffic with sporadic requests and back-pressure.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      dividend  = 16'($urandom);
      divisor   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end

    // Back-to-back requests: in_valid stays high and the operands change every cycle.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'b1;
      dividend  = 16'($urandom);
      divisor   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("drain_idle",     32'(in_ready), 32'd1);
    chk("deliv_vs_model", 32'(d_del),    32'(m_del));
    chk("acc_vs_deliv",   32'(m_acc),    32'(m_del));
    chk("acc_nonzero",    32'(m_acc > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/divider_seq_16x8.md
DIVIDER_SEQ_16X8 -- requirements
Module: divider_seq_16x8

Interface
REQ-001 Parameters: none; operand widths are fixed at 16-bit dividend and 8-bit divisor, the inverse of the team's 8x8 registered multiplier.
REQ-002 One clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 dividend  input  16  unsigned dividend.
REQ-008 divisor  input  8  unsigned divisor.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  16  unsigned quotient.
REQ-012 remainder  output  8  unsigned remainder.
REQ-013 div_by_zero  output  1  divisor was zero; qualified by out_valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance: on an edge with in_valid=1 in IDLE, the block SHALL latch dividend and divisor, clear the partial remainder and step counter, and go to BUSY.
REQ-017 BUSY SHALL perform one restoring-division step per clock, MSB first:
- rem9 = {rem, next dividend bit};
- if rem9 >= divisor: rem = rem9 - divisor and the quotient bit = 1;
- else: rem = rem9[7:0] and the quotient bit = 0.
REQ-018 After exactly 16 BUSY steps, the block SHALL enter DONE; out_valid SHALL rise on the 17th rising edge after the acceptance edge.
REQ-019 Results SHALL satisfy quotient*divisor + remainder == dividend with remainder < divisor whenever divisor != 0.
REQ-020 In DONE, quotient, remainder and div_by_zero SHALL stay stable while out_ready=0, for any number of cycles.
REQ-021 On an edge with out_valid=1 and out_ready=1, the block SHALL return to IDLE. No new operand is accepted on that same edge, because in_ready=0 in DONE.
REQ-022 Outputs SHALL hold their last values in IDLE and BUSY; only out_valid qualifies them.
REQ-023 in_valid, dividend and divisor SHALL be ignored outside IDLE; operands SHALL NOT be re-sampled during BUSY.
REQ-024 Divisor zero without early termination SHALL yield quotient=16'hFFFF and remainder=dividend[7:0] as a natural consequence of REQ-017.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE. quotient, remainder, div_by_zero, out_valid, the internal operands, the partial remainder and the counter SHALL all be 0; in_ready SHALL be 1.
REQ-026 Reset asserted during BUSY or DONE SHALL abort the operation with no result produced; the first post-reset acceptance SHALL behave as from power-up.

Configuration
REQ-027 Macro DIV_ZERO_CHECK_EN.
- Defined: on acceptance with divisor=0, the block SHALL skip BUSY and enter DONE on the next edge (out_valid one edge after acceptance). It SHALL set quotient=16'hFFFF, remainder=dividend[7:0] and div_by_zero=1. div_by_zero SHALL be 0 for nonzero divisors.
- Undefined: divisor=0 SHALL take the full 16 steps per REQ-024, and div_by_zero SHALL be tied to 0.

Verification
REQ-028 dividend=1000, divisor=7 -> quotient=142, remainder=6, out_valid on edge 17 after acceptance, div_by_zero=0.
REQ-029 dividend=16'hFFFF, divisor=255 -> quotient=257, remainder=0. Also dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0.
REQ-030 dividend=100, divisor=0 ->
- with DIV_ZERO_CHECK_EN: out_valid on edge 1, quotient=16'hFFFF, remainder=8'h64, div_by_zero=1;
- without it: same values on edge 17, div_by_zero=0.
REQ-031 dividend=12345, divisor=10 with out_ready held 0 for 5 cycles in DONE -> quotient=1234 and remainder=5 held stable, in_ready=0 throughout, IDLE one edge after out_ready=1.
REQ-032 rst_n pulsed low after 8 BUSY steps of 5000/3 -> all outputs 0 and in_ready=1 immediately. A following 200/9 -> quotient=22, remainder=2 on edge 17.
REQ-033 Back-to-back: in_valid held 1 with a new operand pair each cycle -> the block accepts only in IDLE, with exactly one result per accepted pair and no lost or duplicated results.
